// File: rtl/dual_port_ram_4096.sv
// Simple dual-port RAM with per-word valid bits: unwritten words read as zero,
// and reset invalidates the whole array asynchronously.
module dual_port_ram_4096 #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out
);

  // No handshake: write/read are enables sampled at each rising edge and every
  // enabled access completes at that edge; there is no busy or stall.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;

  logic same_addr;
  assign same_addr = write && (wr_address == rd_address);

  // Storage is never cleared; the valid bits mask stale contents.
  always_ff @(posedge clock) begin
    if (write && !reset) begin
      mem[wr_address] <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (write) begin
      valid[wr_address] <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= '0;
    end else if (read) begin
      if (same_addr) begin
        data_out <= data_in;
      end else if (valid[rd_address]) begin
        data_out <= mem[rd_address];
      end else begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram_4096.sv
// Bench for dual_port_ram_4096: associative-array reference model checked every
// cycle, plus directed vectors with literal expected values.
module tb_dual_port_ram_4096;

  localparam int DW = 64;
  localparam int AW = 12;

  logic          clock;
  logic          reset;
  logic [DW-1:0] data_in;
  logic [AW-1:0] wr_address;
  logic          write;
  logic [AW-1:0] rd_address;
  logic          read;
  logic [DW-1:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  dual_port_ram_4096 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(4096)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .wr_address (wr_address),
    .write      (write),
    .rd_address (rd_address),
    .read       (read),
    .data_out   (data_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory is a sparse map of written words; a write at an edge is applied
  // before the read at that same edge, so the read sees the new word.
  logic [DW-1:0] model [int];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] cur_exp = '0;
  bit            reset_seen = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      model.delete();
      exp_q.push_back('0);
      reset_seen = 1'b1;
    end else begin
      if (write) model[int'(wr_address)] = data_in;
      if (read) exp_q.push_back(model.exists(int'(rd_address)) ? model[int'(rd_address)] : '0);
    end
  end

  always @(negedge clock) begin
    if (reset_seen) begin
      while (exp_q.size() > 0) cur_exp = exp_q.pop_front();
      check("data_out_model", data_out, cur_exp);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic r, input logic [AW-1:0] ra);
    @(negedge clock);
    write      = w;
    wr_address = wa;
    data_in    = wd;
    read       = r;
    rd_address = ra;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0;
    write = 1'b0; read = 1'b0;
    data_in = '0; wr_address = '0; rd_address = '0;
    #1 reset = 1'b1;
    #1 check("reset_data_out", data_out, 64'h0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;

    // reads of never-written boundary words
    step(1'b0, '0, '0, 1'b1, 12'h000);
    check("rd_unwritten_000", data_out, 64'h0);
    step(1'b0, '0, '0, 1'b1, 12'hFFF);
    check("rd_unwritten_fff", data_out, 64'h0);

    // write then read
    step(1'b1, 12'h0A5, 64'hDEAD_BEEF_0123_4567, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 12'h0A5);
    check("wr_then_rd_0a5", data_out, 64'hDEAD_BEEF_0123_4567);

    // same-address bypass
    step(1'b1, 12'h010, 64'h1111_2222_3333_4444, 1'b1, 12'h010);
    check("bypass_010", data_out, 64'h1111_2222_3333_4444);

    // different addresses in the same cycle
    step(1'b1, 12'h020, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, '0);
    step(1'b1, 12'h021, 64'h5555_5555_5555_5555, 1'b1, 12'h020);
    check("diff_addr_rd_020", data_out, 64'hAAAA_AAAA_AAAA_AAAA);
    step(1'b0, '0, '0, 1'b1, 12'h021);
    check("later_rd_021", data_out, 64'h5555_5555_5555_5555);

    // boundary addresses, back-to-back reads, then hold
    step(1'b1, 12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0);
    step(1'b1, 12'h000, 64'h0000_0000_0000_0001, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 12'hFFF);
    check("rd_fff", data_out, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b0, '0, '0, 1'b1, 12'h000);
    check("rd_000", data_out, 64'h0000_0000_0000_0001);
    for (int i = 0; i < 5; i++) begin
      idle();
      check($sformatf("hold_%0d", i), data_out, 64'h0000_0000_0000_0001);
    end

    // reset between edges clears output immediately and discards writes
    step(1'b1, 12'h100, 64'h0000_0000_00C0_FFEE, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 12'h100);
    check("rd_100", data_out, 64'h0000_0000_00C0_FFEE);
    #2 reset = 1'b1;
    #1 check("async_reset_out", data_out, 64'h0);

    // accesses while reset is held are ignored
    @(negedge clock);
    write = 1'b1; wr_address = 12'h200; data_in = 64'h0123_0123_0123_0123;
    read = 1'b1; rd_address = 12'h0A5;
    @(posedge clock);
    #1 check("reset_ignores_read", data_out, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    write = 1'b0; read = 1'b0;

    step(1'b0, '0, '0, 1'b1, 12'h100);
    check("post_reset_100", data_out, 64'h0);
    step(1'b0, '0, '0, 1'b1, 12'h0A5);
    check("post_reset_0a5", data_out, 64'h0);
    step(1'b0, '0, '0, 1'b1, 12'h200);
    check("wr_during_reset_200", data_out, 64'h0);

    // rewrite after reset is visible again
    step(1'b1, 12'h100, 64'hCAFE_F00D_0000_0042, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 12'h100);
    check("rewrite_100", data_out, 64'hCAFE_F00D_0000_0042);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
